// File: rtl/fwupd_bank_uaddr.sv
// Firmware-update URAM write-address generator with N-bank ping-pong and per-bank FULL tracking.
// Optional per-bank word counters are built when FWUPD_UADDR_WORDCNT_EN is defined.
module fwupd_bank_uaddr #(
    parameter int WORD_BITS = 7,
    parameter int NBANKS    = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                ce_i,
    input  logic                                mark_i,
    input  logic [NBANKS-1:0]                   release_i,
    output logic [$clog2(NBANKS)+WORD_BITS-1:0] uaddr_o,
    output logic                                ready_o,
    output logic [NBANKS-1:0]                   full_o,
    output logic                                overflow_o
`ifdef FWUPD_UADDR_WORDCNT_EN
    ,
    output logic [NBANKS*(WORD_BITS+1)-1:0]     wcount_o
`endif
);

    localparam int BANK_BITS = $clog2(NBANKS);
    localparam int CNT_BITS  = WORD_BITS + 1;
    localparam logic [WORD_BITS-1:0] WORD_MAX = {WORD_BITS{1'b1}};
    localparam logic [WORD_BITS-1:0] WORD_INC = WORD_BITS'(1);
    localparam logic [BANK_BITS-1:0] BANK_INC = BANK_BITS'(1);
    localparam logic [NBANKS-1:0]    BANK_ONE = NBANKS'(1);

    logic [WORD_BITS-1:0] r_word;
    logic [BANK_BITS-1:0] r_bank;
    logic [NBANKS-1:0]    r_full;
    logic                 r_ovf;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_close;
    logic                 w_reject;
    logic [NBANKS-1:0]    w_close_vec;
    logic [NBANKS-1:0]    w_full_nxt;

    // Acceptance is judged on pre-release FULL state, so a same-cycle release never admits a write.
    always_comb begin
        w_ready     = ~r_full[r_bank];
        w_accept    = ce_i & w_ready;
        w_close     = w_ready & (mark_i | (ce_i & (r_word == WORD_MAX)));
        w_reject    = (ce_i | mark_i) & ~w_ready;
        w_close_vec = {NBANKS{1'b0}};
        if (w_close) begin
            w_close_vec = BANK_ONE << r_bank;
        end else begin
            w_close_vec = {NBANKS{1'b0}};
        end
        // A close only targets a non-full bank, so it can never collide with a release of that bank.
        w_full_nxt  = (r_full & ~release_i) | w_close_vec;
    end

    // Address, bank pointer, FULL flags and sticky overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_word <= {WORD_BITS{1'b0}};
            r_bank <= {BANK_BITS{1'b0}};
            r_full <= {NBANKS{1'b0}};
            r_ovf  <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            r_ovf  <= r_ovf | w_reject;
            if (w_close) begin
                r_word <= {WORD_BITS{1'b0}};
                r_bank <= r_bank + BANK_INC;
            end else if (w_accept) begin
                r_word <= r_word + WORD_INC;
                r_bank <= r_bank;
            end else begin
                r_word <= r_word;
                r_bank <= r_bank;
            end
        end
    end

`ifdef FWUPD_UADDR_WORDCNT_EN
    logic [NBANKS*CNT_BITS-1:0] r_wcount;
    logic [CNT_BITS-1:0]        w_count;

    // Words written into the closing bank, including a write that lands in the closing cycle.
    always_comb begin
        w_count = {1'b0, r_word} + CNT_BITS'(w_accept);
    end

    // Count registers hold until the same bank closes again; releases leave them untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wcount <= {(NBANKS*CNT_BITS){1'b0}};
        end else if (w_close) begin
            r_wcount[int'(r_bank)*CNT_BITS +: CNT_BITS] <= w_count;
        end else begin
            r_wcount <= r_wcount;
        end
    end

    assign wcount_o = r_wcount;
`endif

    assign uaddr_o    = {r_bank, r_word};
    assign ready_o    = w_ready;
    assign full_o     = r_full;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_fwupd_bank_uaddr.sv
// Scoreboard bench for fwupd_bank_uaddr: a 2x128 instance (A) and a 4x8 instance (B).
module tb_fwupd_bank_uaddr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b0, a_ce = 1'b0, a_mark = 1'b0;
    logic [1:0]  a_rel = 2'b00;
    logic [7:0]  a_uaddr;
    logic        a_ready, a_ovf;
    logic [1:0]  a_full;
    logic        b_rst = 1'b0, b_ce = 1'b0, b_mark = 1'b0;
    logic [3:0]  b_rel = 4'b0000;
    logic [4:0]  b_uaddr;
    logic        b_ready, b_ovf;
    logic [3:0]  b_full;
`ifdef FWUPD_UADDR_WORDCNT_EN
    logic [15:0] a_wcount;
    logic [15:0] b_wcount;
`endif

    fwupd_bank_uaddr #(.WORD_BITS(7), .NBANKS(2)) u_dut_a (
        .clk_i(clk), .rst_i(a_rst), .ce_i(a_ce), .mark_i(a_mark), .release_i(a_rel),
        .uaddr_o(a_uaddr), .ready_o(a_ready), .full_o(a_full), .overflow_o(a_ovf)
`ifdef FWUPD_UADDR_WORDCNT_EN
        , .wcount_o(a_wcount)
`endif
    );

    fwupd_bank_uaddr #(.WORD_BITS(3), .NBANKS(4)) u_dut_b (
        .clk_i(clk), .rst_i(b_rst), .ce_i(b_ce), .mark_i(b_mark), .release_i(b_rel),
        .uaddr_o(b_uaddr), .ready_o(b_ready), .full_o(b_full), .overflow_o(b_ovf)
`ifdef FWUPD_UADDR_WORDCNT_EN
        , .wcount_o(b_wcount)
`endif
    );

    typedef struct packed {
        logic        sel;
        logic        chk_wc;
        logic [7:0]  uaddr;
        logic [3:0]  full;
        logic        ready;
        logic        ovf;
        logic [1:0]  wc_idx;
        logic [8:0]  wc_val;
        logic [31:0] due;
    } exp_t;

    exp_t  q_exp[$];
    string q_name[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops every expectation that is due at this falling edge and compares it.
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        logic [8:0] wc;
        while (q_exp.size() > 0 && int'(q_exp[0].due) <= cyc) begin
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            if (int'(e.due) < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s: stale expectation, due %0d, now %0d", nm, e.due, cyc);
            end else if (e.chk_wc) begin
                wc = 9'd0;
`ifdef FWUPD_UADDR_WORDCNT_EN
                if (e.sel) wc = {5'd0, b_wcount[int'(e.wc_idx)*4 +: 4]};
                else       wc = {1'b0, a_wcount[int'(e.wc_idx)*8 +: 8]};
`endif
                cmp({nm, ".wcount"}, {23'd0, wc}, {23'd0, e.wc_val});
            end else begin
                cmp({nm, ".uaddr"}, e.sel ? {27'd0, b_uaddr} : {24'd0, a_uaddr}, {24'd0, e.uaddr});
                cmp({nm, ".full"},  e.sel ? {28'd0, b_full} : {30'd0, a_full}, {28'd0, e.full});
                cmp({nm, ".ready"}, {31'd0, e.sel ? b_ready : a_ready}, {31'd0, e.ready});
                cmp({nm, ".ovf"},   {31'd0, e.sel ? b_ovf : a_ovf}, {31'd0, e.ovf});
            end
        end
    end

    // One clock of stimulus on one instance; the other instance idles.
    task automatic drive(input logic sel, input logic rst, input logic ce, input logic mark,
                         input logic [3:0] rel);
        if (sel) begin
            b_rst = rst; b_ce = ce; b_mark = mark; b_rel = rel;
        end else begin
            a_rst = rst; a_ce = ce; a_mark = mark; a_rel = rel[1:0];
        end
        @(posedge clk);
        #1;
        a_rst = 1'b0; a_ce = 1'b0; a_mark = 1'b0; a_rel = 2'b00;
        b_rst = 1'b0; b_ce = 1'b0; b_mark = 1'b0; b_rel = 4'b0000;
    endtask

    task automatic expect_st(input logic sel, input string nm, input logic [7:0] uaddr,
                             input logic [3:0] full, input logic ready, input logic ovf);
        exp_t e;
        e = '0;
        e.sel = sel; e.uaddr = uaddr; e.full = full; e.ready = ready; e.ovf = ovf;
        e.due = 32'(cyc);
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic expect_wc(input logic sel, input string nm, input logic [1:0] idx,
                             input logic [8:0] val);
`ifdef FWUPD_UADDR_WORDCNT_EN
        exp_t e;
        e = '0;
        e.sel = sel; e.chk_wc = 1'b1; e.wc_idx = idx; e.wc_val = val;
        e.due = 32'(cyc);
        q_exp.push_back(e);
        q_name.push_back(nm);
`else
        if (sel && idx == 2'd3 && val == 9'd511 && nm == "") n_cmp = n_cmp + 0;
`endif
    endtask

    localparam logic A = 1'b0;
    localparam logic B = 1'b1;

    initial begin
        #1;
        a_rst = 1'b1; b_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0; b_rst = 1'b0;
        expect_st(A, "reset_a", 8'h00, 4'h0, 1'b1, 1'b0);
        expect_st(B, "reset_b", 8'h00, 4'h0, 1'b1, 1'b0);

        // Fill bank 0 of A word by word.
        for (int i = 1; i <= 128; i++) begin
            drive(A, 1'b0, 1'b1, 1'b0, 4'h0);
            expect_st(A, $sformatf("t1_w%0d", i), 8'(i), 4'(i == 128), 1'b1, 1'b0);
        end
        // Fill bank 1; both full afterwards.
        for (int k = 1; k <= 128; k++) begin
            drive(A, 1'b0, 1'b1, 1'b0, 4'h0);
            expect_st(A, $sformatf("t2_w%0d", k), 8'((128 + k) % 256),
                      (k == 128) ? 4'h3 : 4'h1, (k < 128) ? 1'b1 : 1'b0, 1'b0);
        end
        expect_wc(A, "t2_wc0", 2'd0, 9'd128);
        expect_wc(A, "t2_wc1", 2'd1, 9'd128);
        drive(A, 1'b0, 1'b1, 1'b0, 4'h0);
        expect_st(A, "t2_reject", 8'h00, 4'h3, 1'b0, 1'b1);

        drive(A, 1'b0, 1'b0, 1'b0, 4'h1);
        expect_st(A, "t3_release", 8'h00, 4'h2, 1'b1, 1'b1);
        drive(A, 1'b0, 1'b1, 1'b0, 4'h0);
        expect_st(A, "t3_write", 8'h01, 4'h2, 1'b1, 1'b1);
        drive(A, 1'b0, 1'b0, 1'b0, 4'h1);
        expect_st(A, "t3_rel_notfull", 8'h01, 4'h2, 1'b1, 1'b1);

        // Partial bank closed by ce+mark, then a zero-length bank.
        drive(A, 1'b1, 1'b0, 1'b0, 4'h0);
        expect_st(A, "t4_reset", 8'h00, 4'h0, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            drive(A, 1'b0, 1'b1, 1'b0, 4'h0);
            expect_st(A, $sformatf("t4_w%0d", i), 8'(i), 4'h0, 1'b1, 1'b0);
        end
        drive(A, 1'b0, 1'b1, 1'b1, 4'h0);
        expect_st(A, "t4_ce_mark", 8'h80, 4'h1, 1'b1, 1'b0);
        expect_wc(A, "t4_wc0", 2'd0, 9'd6);
        drive(A, 1'b0, 1'b0, 1'b1, 4'h0);
        expect_st(A, "t4_mark_empty", 8'h00, 4'h3, 1'b0, 1'b0);
        expect_wc(A, "t4_wc1", 2'd1, 9'd0);
        drive(A, 1'b0, 1'b0, 1'b1, 4'h0);
        expect_st(A, "t4_mark_reject", 8'h00, 4'h3, 1'b0, 1'b1);
        drive(A, 1'b0, 1'b1, 1'b0, 4'h3);
        expect_st(A, "t4_ce_with_release", 8'h00, 4'h0, 1'b1, 1'b1);
        expect_wc(A, "t4_wc0_kept", 2'd0, 9'd6);

        // ce+mark on the last word: exactly one bank advance.
        for (int i = 1; i <= 127; i++) drive(A, 1'b0, 1'b1, 1'b0, 4'h0);
        expect_st(A, "t4b_w127", 8'h7F, 4'h0, 1'b1, 1'b1);
        drive(A, 1'b0, 1'b1, 1'b1, 4'h0);
        expect_st(A, "t4b_last_mark", 8'h80, 4'h1, 1'b1, 1'b1);
        expect_wc(A, "t4b_wc0", 2'd0, 9'd128);

        // Reset mid-bank with bank 1 full and overflow set.
        drive(A, 1'b1, 1'b0, 1'b0, 4'h0);
        drive(A, 1'b0, 1'b0, 1'b1, 4'h0);
        expect_st(A, "t6_mark0", 8'h80, 4'h1, 1'b1, 1'b0);
        drive(A, 1'b0, 1'b0, 1'b1, 4'h0);
        drive(A, 1'b0, 1'b0, 1'b1, 4'h0);
        expect_st(A, "t6_ovf", 8'h00, 4'h3, 1'b0, 1'b1);
        drive(A, 1'b0, 1'b0, 1'b0, 4'h1);
        for (int i = 1; i <= 69; i++) drive(A, 1'b0, 1'b1, 1'b0, 4'h0);
        expect_st(A, "t6_w45", 8'h45, 4'h2, 1'b1, 1'b1);
        drive(A, 1'b1, 1'b1, 1'b0, 4'h0);
        expect_st(A, "t6_reset", 8'h00, 4'h0, 1'b1, 1'b0);
        expect_wc(A, "t6_wc0", 2'd0, 9'd0);

        // Four banks of eight words; wraps back to bank 0.
        for (int k = 1; k <= 32; k++) begin
            drive(B, 1'b0, 1'b1, 1'b0, 4'h0);
            expect_st(B, $sformatf("t5_w%0d", k), 8'(k % 32), 4'((1 << (k / 8)) - 1),
                      (k < 32) ? 1'b1 : 1'b0, 1'b0);
        end
        expect_wc(B, "t5_wc3", 2'd3, 9'd8);
        drive(B, 1'b0, 1'b0, 1'b0, 4'h4);
        expect_st(B, "t5_rel2", 8'h00, 4'hB, 1'b0, 1'b0);
        drive(B, 1'b0, 1'b1, 1'b0, 4'h0);
        expect_st(B, "t5_blocked", 8'h00, 4'hB, 1'b0, 1'b1);
        drive(B, 1'b0, 1'b1, 1'b0, 4'h1);
        expect_st(B, "t5_rel0_ce", 8'h00, 4'hA, 1'b1, 1'b1);
        drive(B, 1'b0, 1'b1, 1'b0, 4'h0);
        expect_st(B, "t5_resume", 8'h01, 4'hA, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        #1;
        while (q_exp.size() > 0) begin
            void'(q_exp.pop_front());
            $display("FAIL %s: expectation never checked", q_name.pop_front());
            n_cmp++;
            n_fail++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
